// File: rtl/kmkz_rf_pkg.sv
// Shared types and helpers for the kmkz_regfile_np register file.
package kmkz_rf_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int RV32I_NREGS = 32;
   localparam int RV32E_NREGS = 16;

   function automatic logic rf_in_range(input logic [31:0] addr, input int nregs);
      return addr < 32'(nregs);
   endfunction

endpackage

// File: rtl/kmkz_rf_readport.sv
// One registered read port: held address, operand register, illegal flag,
// stall-time refresh from the write port and the X-stage bypass mux.
module kmkz_rf_readport
   import kmkz_rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = RV32I_NREGS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ready_i,
   input  logic              stall_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [DATA_W-1:0] rf_data_i,
   input  logic              upd_en_i,
   input  logic [ADDR_W-1:0] upd_addr_i,
   input  logic [DATA_W-1:0] upd_data_i,
   input  logic [ADDR_W-1:0] d_rs_i,
   input  logic              byp_en_i,
   input  logic [ADDR_W-1:0] byp_addr_i,
   input  logic [DATA_W-1:0] byp_data_i,
   output logic [DATA_W-1:0] value_o,
   output logic              illegal_o
);

   logic [ADDR_W-1:0] held_q, held_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic              ill_q, ill_d;
   logic              rs_in_range;

   assign rs_in_range = rf_in_range(32'(rs_addr_i), NREGS);

   always_comb begin
      // NOTE: every next-state value gets its hold default first, so no latch is inferred.
      held_d = held_q;
      val_d  = val_q;
      ill_d  = ill_q;
      if (ready_i && !stall_i) begin
         held_d = rs_addr_i;
         ill_d  = !rs_in_range;
         if (rs_addr_i == '0 || !rs_in_range) begin
            val_d = '0;
         end else if (upd_en_i && upd_addr_i == rs_addr_i) begin
            val_d = upd_data_i;
         end else begin
            val_d = rf_data_i;
         end
      end else if (stall_i && upd_en_i && upd_addr_i == held_q) begin
         // A stalled operand follows writes to its register so it never goes stale.
         val_d = upd_data_i;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         held_q <= '0;
         val_q  <= '0;
         ill_q  <= 1'b0;
      end else begin
         held_q <= held_d;
         val_q  <= val_d;
         ill_q  <= ill_d;
      end
   end

   assign value_o   = (byp_en_i && byp_addr_i == d_rs_i && byp_addr_i != '0) ? byp_data_i : val_q;
   assign illegal_o = ill_q;

endmodule

// File: rtl/kmkz_regfile_np.sv
// N-read / 1-write register file with post-reset clear sequencer and X bypass.
// Optional debug access port enabled by defining KMKZ_RF_DEBUG_EN.
module kmkz_regfile_np
   import kmkz_rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = RV32I_NREGS,
   parameter int N_RD   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     d_stall_i,
   input  logic [N_RD*ADDR_W-1:0]   rf_rs_i,
   input  logic [N_RD*ADDR_W-1:0]   d_rs_i,
   output logic [N_RD*DATA_W-1:0]   x_rs_value_o,
   output logic [N_RD-1:0]          x_rs_illegal_o,
   input  logic [ADDR_W-1:0]        w_rd_i,
   input  logic [DATA_W-1:0]        w_rd_value_i,
   input  logic                     w_rd_store_i,
   input  logic                     w_bypass_rd_write_i,
   input  logic [DATA_W-1:0]        w_bypass_rd_value_i,
`ifdef KMKZ_RF_DEBUG_EN
   input  logic                     dbg_req_i,
   input  logic                     dbg_we_i,
   input  logic [ADDR_W-1:0]        dbg_addr_i,
   input  logic [DATA_W-1:0]        dbg_wdata_i,
   output logic [DATA_W-1:0]        dbg_rdata_o,
   output logic                     dbg_ack_o,
`endif
   output logic                     busy_o
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   rf_state_e         state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] regs_q [NREGS];

   logic              wr;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              upd_en;
   logic [ADDR_W-1:0] upd_addr;
   logic [DATA_W-1:0] upd_data;
   logic              dbg_wr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CLEAR;
         clr_cnt_q <= IDX_W'(1);
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == IDX_W'(NREGS - 1)) state_d = READY;
      end
   end

   assign busy_o = (state_q == CLEAR);
   assign wr     = w_rd_store_i && (state_q == READY) && (w_rd_i != '0)
                   && rf_in_range(32'(w_rd_i), NREGS);

`ifdef KMKZ_RF_DEBUG_EN
   logic              dbg_grant;
   logic              dbg_ack_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              dbg_addr_ok;

   // One access in flight: no new grant while the previous ack is being presented.
   assign dbg_addr_ok = (dbg_addr_i != '0) && rf_in_range(32'(dbg_addr_i), NREGS);
   assign dbg_grant   = dbg_req_i && (state_q == READY) && !wr && !dbg_ack_q;
   assign dbg_wr      = dbg_grant && dbg_we_i && dbg_addr_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         dbg_ack_q <= dbg_grant;
         if (dbg_grant) dbg_rdata_q <= dbg_addr_ok ? regs_q[dbg_addr_i[IDX_W-1:0]] : '0;
      end
   end

   assign dbg_ack_o   = dbg_ack_q;
   assign dbg_rdata_o = dbg_rdata_q;
`else
   assign dbg_wr = 1'b0;
`endif

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      upd_en    = 1'b0;
      upd_addr  = w_rd_i;
      upd_data  = w_rd_value_i;
      if (state_q == CLEAR) begin
         mem_we = 1'b1;
      end else if (wr) begin
         mem_we    = 1'b1;
         mem_waddr = w_rd_i[IDX_W-1:0];
         mem_wdata = w_rd_value_i;
         upd_en    = 1'b1;
      end else if (dbg_wr) begin
`ifdef KMKZ_RF_DEBUG_EN
         mem_we    = 1'b1;
         mem_waddr = dbg_addr_i[IDX_W-1:0];
         mem_wdata = dbg_wdata_i;
         upd_en    = 1'b1;
         upd_addr  = dbg_addr_i;
         upd_data  = dbg_wdata_i;
`endif
      end
   end

   // NOTE: the array has no reset term; the clear sequencer zeroes it after reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) regs_q[mem_waddr] <= mem_wdata;
   end

   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] rs_addr;

      assign rs_addr = rf_rs_i[k*ADDR_W +: ADDR_W];

      kmkz_rf_readport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NREGS  (NREGS)
      ) u_port (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .ready_i    (state_q == READY),
         .stall_i    (d_stall_i),
         .rs_addr_i  (rs_addr),
         .rf_data_i  (regs_q[rs_addr[IDX_W-1:0]]),
         .upd_en_i   (upd_en),
         .upd_addr_i (upd_addr),
         .upd_data_i (upd_data),
         .d_rs_i     (d_rs_i[k*ADDR_W +: ADDR_W]),
         .byp_en_i   (w_bypass_rd_write_i),
         .byp_addr_i (w_rd_i),
         .byp_data_i (w_bypass_rd_value_i),
         .value_o    (x_rs_value_o[k*DATA_W +: DATA_W]),
         .illegal_o  (x_rs_illegal_o[k])
      );
   end

endmodule

// File: tb/tb_kmkz_regfile_np.sv
// Directed bench for kmkz_regfile_np: an RV32I and an RV32E instance share stimulus
// and are compared every cycle against an architectural register model.
module tb_kmkz_regfile_np;

   localparam int N_RD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [9:0]  rf_rs;
   logic [9:0]  d_rs;
   logic [4:0]  w_rd;
   logic [31:0] w_val;
   logic        store;
   logic        byp;
   logic [31:0] byp_val;
   logic [63:0] val32, val16;
   logic [1:0]  ill32, ill16;
   logic        busy32, busy16;
   logic        dbg_req, dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
`ifdef KMKZ_RF_DEBUG_EN
   logic [31:0] dbg_rdata32, dbg_rdata16;
   logic        dbg_ack32, dbg_ack16;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   kmkz_regfile_np #(.NREGS(32), .N_RD(N_RD)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .d_stall_i(stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs),
      .x_rs_value_o(val32), .x_rs_illegal_o(ill32), .w_rd_i(w_rd), .w_rd_value_i(w_val),
      .w_rd_store_i(store), .w_bypass_rd_write_i(byp), .w_bypass_rd_value_i(byp_val),
`ifdef KMKZ_RF_DEBUG_EN
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_rdata_o(dbg_rdata32), .dbg_ack_o(dbg_ack32),
`endif
      .busy_o(busy32)
   );

   kmkz_regfile_np #(.NREGS(16), .N_RD(N_RD)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .d_stall_i(stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs),
      .x_rs_value_o(val16), .x_rs_illegal_o(ill16), .w_rd_i(w_rd), .w_rd_value_i(w_val),
      .w_rd_store_i(store), .w_bypass_rd_write_i(byp), .w_bypass_rd_value_i(byp_val),
`ifdef KMKZ_RF_DEBUG_EN
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_rdata_o(dbg_rdata16), .dbg_ack_o(dbg_ack16),
`endif
      .busy_o(busy16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural model: registers as seen by software, plus the index each port holds.
   // A held operand always shows the current content of its register.
   int          nr [2] = '{32, 16};
   logic [31:0] mmem  [2][32];
   logic [4:0]  mheld [2][N_RD];
   logic        mill  [2][N_RD];
   int          mbusy [2];
   logic        model_on = 1'b0;

   always @(posedge clk) begin
      if (rst) model_on <= 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            mbusy[c] <= nr[c] - 1;
            for (int r = 0; r < 32; r++) mmem[c][r] <= '0;
            for (int k = 0; k < N_RD; k++) begin
               mheld[c][k] <= '0;
               mill[c][k]  <= 1'b0;
            end
         end else begin
            if (mbusy[c] > 0) mbusy[c] <= mbusy[c] - 1;
            if (store && mbusy[c] == 0 && w_rd != 0 && int'(w_rd) < nr[c]) mmem[c][w_rd] <= w_val;
            if (mbusy[c] == 0 && !stall) begin
               for (int k = 0; k < N_RD; k++) begin
                  mheld[c][k] <= rf_rs[k*5 +: 5];
                  mill[c][k]  <= int'(rf_rs[k*5 +: 5]) >= nr[c];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("busy32", 32'(busy32), 32'(mbusy[0] > 0));
         check("busy16", 32'(busy16), 32'(mbusy[1] > 0));
         for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < N_RD; k++) begin
               logic [31:0] exp_v;
               logic [31:0] act_v;
               logic        act_i;
               if (byp && w_rd == d_rs[k*5 +: 5] && w_rd != 0) exp_v = byp_val;
               else if (int'(mheld[c][k]) < nr[c])             exp_v = mmem[c][mheld[c][k]];
               else                                            exp_v = '0;
               act_v = (c == 0) ? val32[k*32 +: 32] : val16[k*32 +: 32];
               act_i = (c == 0) ? ill32[k] : ill16[k];
               check($sformatf("model_val_n%0d_p%0d", nr[c], k), act_v, exp_v);
               check($sformatf("model_ill_n%0d_p%0d", nr[c], k), 32'(act_i), 32'(mill[c][k]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_set(input logic [4:0] rd, input logic [31:0] v);
      store = 1'b1;
      w_rd  = rd;
      w_val = v;
   endtask

   task automatic count_busy(input string tag);
      int c32 = 0;
      int c16 = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy32) c32++;
         if (busy16) c16++;
         if (i == 2) store = 1'b0;
         tick();
      end
      check({tag, "_busy_cycles32"}, 32'(c32), 32'd31);
      check({tag, "_busy_cycles16"}, 32'(c16), 32'd15);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; rf_rs = '0; d_rs = '0; w_rd = '0; w_val = '0;
      store = 1'b0; byp = 1'b0; byp_val = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // 1. one reset cycle, writes during CLEAR are dropped
      tick();
      rst = 1'b0;
      check("reset_busy32", 32'(busy32), 32'd1);
      check("reset_val32", val32[31:0], 32'd0);
      wr_set(5'd5, 32'hDEAD);
      count_busy("clr");
      rf_rs = {5'd0, 5'd5};
      tick();
      check("x5_dropped", val32[31:0], 32'h0);

      // 2. read-during-write on capture
      wr_set(5'd3, 32'h12345678);
      rf_rs = {5'd0, 5'd3};
      tick();
      store = 1'b0;
      check("rdw_x3_32", val32[31:0], 32'h12345678);
      check("rdw_x3_16", val16[31:0], 32'h12345678);

      // 3. stalled operand refreshed by a write to its register
      wr_set(5'd7, 32'h11);
      tick();
      store = 1'b0;
      rf_rs = {5'd7, 5'd0};
      tick();
      check("cap_x7", val32[63:32], 32'h11);
      stall = 1'b1;
      rf_rs = {5'd3, 5'd0};
      tick();
      wr_set(5'd7, 32'h22);
      tick();
      store = 1'b0;
      check("stall_upd_x7", val32[63:32], 32'h22);
      tick();
      check("stall_hold_x7", val32[63:32], 32'h22);
      stall = 1'b0;

      // 4. X bypass, and no bypass for x0
      wr_set(5'd4, 32'h1);
      rf_rs = {5'd0, 5'd4};
      tick();
      store = 1'b0;
      d_rs = {5'd0, 5'd4}; byp = 1'b1; byp_val = 32'hCAFE; w_rd = 5'd4;
      #1;
      check("xbyp_hit", val32[31:0], 32'hCAFE);
      w_rd = 5'd0;
      #1;
      check("xbyp_x0", val32[31:0], 32'h1);
      tick();
      byp = 1'b0; d_rs = '0;

      // 5. out-of-range index on RV32E
      rf_rs = {5'd0, 5'd20};
      tick();
      check("oor_val16", val16[31:0], 32'h0);
      check("oor_ill16", 32'(ill16[0]), 32'd1);
      check("oor_ill32", 32'(ill32[0]), 32'd0);
      wr_set(5'd20, 32'hBEEF);
      tick();
      store = 1'b0;
      check("x20_w32", val32[31:0], 32'hBEEF);
      check("x20_w16", val16[31:0], 32'h0);
      rf_rs = {5'd0, 5'd4};
      tick();
      check("x4_kept16", val16[31:0], 32'h1);

      // both ports on the register being written
      wr_set(5'd9, 32'h99);
      rf_rs = {5'd9, 5'd9};
      tick();
      store = 1'b0;
      check("dual_p0", val32[31:0], 32'h99);
      check("dual_p1", val16[63:32], 32'h99);

`ifdef KMKZ_RF_DEBUG_EN
      // 6. debug read waits for a write-back cycle, then acks once
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
      wr_set(5'd8, 32'h5);
      tick();
      store = 1'b0;
      check("dbg_wait_ack", 32'(dbg_ack32), 32'd0);
      tick();
      check("dbg_ack", 32'(dbg_ack32), 32'd1);
      check("dbg_rdata", dbg_rdata32, 32'h12345678);
      dbg_req = 1'b0;
      tick();
      check("dbg_ack_pulse", 32'(dbg_ack32), 32'd0);
`endif

      // reset from READY, then again mid-CLEAR: sequence restarts and memory is cleared
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_busy("reclr");
      rf_rs = {5'd9, 5'd3};
      tick();
      check("x3_cleared", val32[31:0], 32'h0);
      check("x9_cleared", val16[63:32], 32'h0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
